// File: rtl/shallow_fifo_sync_fwft_if.sv
// rtl/shallow_fifo_sync_fwft_if.sv - handshake/status bundle for shallow_fifo_sync_fwft
//
// Groups the write side, read side, flush and status of the FIFO.
//   master : the user of the FIFO (drives clr, wr_en, wr_data, rd_en)
//   slave  : the FIFO itself (drives rd_data, rd_valid and all status flags)
// Signals:
//   clr        flush request, sampled on the clock edge
//   wr_en      write request;  wr_data  word to write
//   rd_en      read request (FWFT: pop of the presented head word)
//   rd_data    read word;      rd_valid read result / head word valid
//   full, empty, prog_full, prog_empty, count   occupancy status
//   overflow, underflow                           one-cycle rejection strobes

interface shallow_fifo_sync_fwft_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 6
);
  logic                   clr;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   full;
  logic                   empty;
  logic                   prog_full;
  logic                   prog_empty;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, prog_full, prog_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, prog_full, prog_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/shallow_fifo_sync_fwft.sv
// rtl/shallow_fifo_sync_fwft.sv - shallow single-clock FIFO with standard or FWFT read
//
// Elastic buffer on a distributed dual-port RAM (sync write, async read).
// Depth need not be a power of two; pointers wrap by explicit compare.
//   FWFT = 0 : rd_data is registered, rd_valid pulses the cycle after an accepted rd_en.
//   FWFT = 1 : an output register holds the head word while rd_valid is high;
//              rd_en pops it. count includes that word, so capacity is FIFO_DEPTH.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (RAM contents are not cleared)
//   io_fifo  slave side of shallow_fifo_sync_fwft_if (write, read, flush, status)

module shallow_fifo_sync_fwft #(
  parameter int DATA_WIDTH        = 8,
  parameter int FIFO_DEPTH        = 32,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = 24,
  parameter int PROG_EMPTY_THRESH = 8,
  parameter int COUNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shallow_fifo_sync_fwft_if.slave io_fifo
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  typedef logic [PTR_WIDTH-1:0]   ptr_t;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  localparam ptr_t LAST_PTR  = ptr_t'(FIFO_DEPTH - 1);
  localparam cnt_t DEPTH_CNT = cnt_t'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  ptr_t                  r_wr_ptr;
  ptr_t                  r_rd_ptr;
  cnt_t                  r_count;     // words held, including the FWFT output register
  cnt_t                  r_ram_cnt;   // words held in RAM only
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_ram_rd;    // RAM word moves to rd_data and rd_ptr advances
  logic w_ram_wr;

  assign w_full = (r_count == DEPTH_CNT);

  always_comb begin
    w_rd_ok  = 1'b0;
    w_ram_rd = 1'b0;
    if (FWFT != 0) begin
      w_rd_ok  = io_fifo.rd_en & r_rd_valid;
      // Refill the output register whenever it is empty or being popped.
      w_ram_rd = (!r_rd_valid | w_rd_ok) & (r_ram_cnt != '0);
    end else begin
      w_rd_ok  = io_fifo.rd_en & (r_count != '0);
      w_ram_rd = w_rd_ok;
    end
  end

  // A pop in the same cycle frees the slot the write lands in.
  assign w_wr_ok  = io_fifo.wr_en & (!w_full | w_rd_ok);
  assign w_ram_wr = w_wr_ok & !io_fifo.clr;

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_mem[r_wr_ptr] <= io_fifo.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ram_cnt   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (io_fifo.clr) begin
      // Flush wins over any request this edge; rd_data deliberately holds.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ram_cnt   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= io_fifo.wr_en & !w_wr_ok;
      r_underflow <= io_fifo.rd_en & !w_rd_ok;

      if (w_wr_ok) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + ptr_t'(1);
      end

      if (w_ram_rd) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + ptr_t'(1);
      end

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase

      case ({w_wr_ok, w_ram_rd})
        2'b10:   r_ram_cnt <= r_ram_cnt + cnt_t'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - cnt_t'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase

      if (FWFT != 0) begin
        if (w_ram_rd) begin
          r_rd_valid <= 1'b1;
        end else if (w_rd_ok) begin
          r_rd_valid <= 1'b0;
        end
      end else begin
        r_rd_valid <= w_rd_ok;
      end
    end
  end

  // Status flags decode registered state only.
  assign io_fifo.rd_data    = r_rd_data;
  assign io_fifo.rd_valid   = r_rd_valid;
  assign io_fifo.full       = w_full;
  assign io_fifo.empty      = (FWFT != 0) ? !r_rd_valid : (r_count == '0);
  assign io_fifo.prog_full  = (int'(r_count) >= PROG_FULL_THRESH);
  assign io_fifo.prog_empty = (int'(r_count) <= PROG_EMPTY_THRESH);
  assign io_fifo.count      = r_count;
  assign io_fifo.overflow   = r_overflow;
  assign io_fifo.underflow  = r_underflow;

endmodule

// File: tb/tb_shallow_fifo_sync_fwft.sv
// tb/tb_shallow_fifo_sync_fwft.sv - scoreboard bench for shallow_fifo_sync_fwft

module tb_shallow_fifo_sync_fwft;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 0: standard depth 32, 1: FWFT depth 5, 2: standard depth 5
  int         sel;
  logic       t_clr;
  logic       t_wr_en;
  logic       t_rd_en;
  logic [7:0] t_wr_data;

  int depth_of [3] = '{32, 5, 5};
  int fwft_of  [3] = '{0, 1, 0};
  int pft_of   [3] = '{24, 4, 4};
  int pet_of   [3] = '{8, 1, 1};

  shallow_fifo_sync_fwft_if #(.DATA_WIDTH(8), .COUNT_WIDTH(6)) if0 ();
  shallow_fifo_sync_fwft_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) if1 ();
  shallow_fifo_sync_fwft_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) if2 ();

  assign if0.clr     = t_clr   && (sel == 0);
  assign if0.wr_en   = t_wr_en && (sel == 0);
  assign if0.rd_en   = t_rd_en && (sel == 0);
  assign if0.wr_data = t_wr_data;
  assign if1.clr     = t_clr   && (sel == 1);
  assign if1.wr_en   = t_wr_en && (sel == 1);
  assign if1.rd_en   = t_rd_en && (sel == 1);
  assign if1.wr_data = t_wr_data;
  assign if2.clr     = t_clr   && (sel == 2);
  assign if2.wr_en   = t_wr_en && (sel == 2);
  assign if2.rd_en   = t_rd_en && (sel == 2);
  assign if2.wr_data = t_wr_data;

  shallow_fifo_sync_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(0),
    .PROG_FULL_THRESH(24), .PROG_EMPTY_THRESH(8), .COUNT_WIDTH(6)
  ) u_std32 (.clk(clk), .rst_n(rst_n), .io_fifo(if0.slave));

  shallow_fifo_sync_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1),
    .PROG_FULL_THRESH(4), .PROG_EMPTY_THRESH(1), .COUNT_WIDTH(4)
  ) u_fwft5 (.clk(clk), .rst_n(rst_n), .io_fifo(if1.slave));

  shallow_fifo_sync_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0),
    .PROG_FULL_THRESH(4), .PROG_EMPTY_THRESH(1), .COUNT_WIDTH(4)
  ) u_std5 (.clk(clk), .rst_n(rst_n), .io_fifo(if2.slave));

  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_full, o_empty, o_pf, o_pe, o_ovf, o_unf;
  int         o_count;

  always_comb begin
    o_rd_data = '0; o_rd_valid = 1'b0; o_full = 1'b0; o_empty = 1'b0;
    o_pf = 1'b0; o_pe = 1'b0; o_ovf = 1'b0; o_unf = 1'b0; o_count = 0;
    case (sel)
      0: begin
        o_rd_data = if0.rd_data; o_rd_valid = if0.rd_valid; o_full = if0.full;
        o_empty = if0.empty; o_pf = if0.prog_full; o_pe = if0.prog_empty;
        o_ovf = if0.overflow; o_unf = if0.underflow; o_count = int'(if0.count);
      end
      1: begin
        o_rd_data = if1.rd_data; o_rd_valid = if1.rd_valid; o_full = if1.full;
        o_empty = if1.empty; o_pf = if1.prog_full; o_pe = if1.prog_empty;
        o_ovf = if1.overflow; o_unf = if1.underflow; o_count = int'(if1.count);
      end
      default: begin
        o_rd_data = if2.rd_data; o_rd_valid = if2.rd_valid; o_full = if2.full;
        o_empty = if2.empty; o_pf = if2.prog_full; o_pe = if2.prog_empty;
        o_ovf = if2.overflow; o_unf = if2.underflow; o_count = int'(if2.count);
      end
    endcase
  end

  // Reference model: exp_q holds every word in the FIFO, oldest first.
  logic [7:0] exp_q [$];
  int         m_cnt;
  int         m_ram;
  bit         m_vld;
  logic [7:0] m_rd_data;
  bit         e_ovf;
  bit         e_unf;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s (dut %0d): observed %0d expected %0d", tag, sel, obs, exp);
    end
  endtask

  task automatic check_status(input string ph);
    int fw;
    fw = fwft_of[sel];
    check({ph, "/count"},      o_count,    m_cnt);
    check({ph, "/full"},       o_full,     int'(m_cnt == depth_of[sel]));
    check({ph, "/empty"},      o_empty,    (fw != 0) ? int'(!m_vld) : int'(m_cnt == 0));
    check({ph, "/prog_full"},  o_pf,       int'(m_cnt >= pft_of[sel]));
    check({ph, "/prog_empty"}, o_pe,       int'(m_cnt <= pet_of[sel]));
    check({ph, "/rd_valid"},   o_rd_valid, int'(m_vld));
    check({ph, "/rd_data"},    o_rd_data,  m_rd_data);
    check({ph, "/overflow"},   o_ovf,      int'(e_ovf));
    check({ph, "/underflow"},  o_unf,      int'(e_unf));
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit cl = 1'b0);
    bit         fw, rd_ok, wr_ok, load;
    logic [7:0] v;
    fw = (fwft_of[sel] != 0);
    t_wr_en = we; t_wr_data = wd; t_rd_en = re; t_clr = cl;
    rd_ok = re && (fw ? m_vld : (m_cnt != 0));
    wr_ok = we && ((m_cnt < depth_of[sel]) || rd_ok);
    if (fw && rd_ok && !cl) begin
      v = exp_q.pop_front();
      check("fwft_pop", o_rd_data, v);
    end
    @(posedge clk);
    #1;
    if (cl) begin
      exp_q.delete();
      m_cnt = 0; m_ram = 0; m_vld = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    end else begin
      e_ovf = we && !wr_ok;
      e_unf = re && !rd_ok;
      if (wr_ok) exp_q.push_back(wd);
      if (fw) begin
        load  = (!m_vld || rd_ok) && (m_ram != 0);
        m_ram = m_ram + int'(wr_ok) - int'(load);
        if (load) begin
          m_vld = 1'b1;
          m_rd_data = exp_q[0];
        end else if (rd_ok) begin
          m_vld = 1'b0;
        end
      end else begin
        m_vld = rd_ok;
        if (rd_ok) begin
          v = exp_q.pop_front();
          check("std_pop", o_rd_data, v);
          m_rd_data = v;
        end
      end
      m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    end
    t_wr_en = 1'b0; t_rd_en = 1'b0; t_clr = 1'b0;
    check_status("step");
  endtask

  // Async reset between clock edges; outputs are checked before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2;
    exp_q.delete();
    m_cnt = 0; m_ram = 0; m_vld = 1'b0; m_rd_data = '0;
    e_ovf = 1'b0; e_unf = 1'b0;
    check_status("reset");
    #1 rst_n = 1'b1;
  endtask

  task automatic run_small();
    logic [7:0] d;
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    d = 8'h10;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin step(1'b1, d, 1'b0); d++; end
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 6; k++) begin step(1'b1, d, 1'b0); d++; end
    for (int k = 0; k < 3; k++) begin step(1'b1, d, 1'b1); d++; end
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1; sel = 0;
    t_clr = 1'b0; t_wr_en = 1'b0; t_rd_en = 1'b0; t_wr_data = '0;
    m_rd_data = '0;
    @(posedge clk);
    #1;

    sel = 0;
    do_reset();
    for (int i = 1; i <= 32; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    sel = 2;
    run_small();

    sel = 1;
    run_small();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hD1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shallow_fifo_sync_fwft.md
Name: shallow_fifo_sync_fwft

Overview:
Parametrised single-clock shallow FIFO built on distributed dual-port RAM (async read, sync write), with selectable read mode.
- Standard mode: registered read data, one cycle after rd_en.
- First-word-fall-through (FWFT) mode: the head word is presented with a valid flag.
Adds non-power-of-two depth, synchronous flush, and overflow/underflow error strobes. Used as the drop-in elastic buffer between streaming sub-blocks.

Parameters:
- DATA_WIDTH, 8, data word width (1..256).
- FIFO_DEPTH, 32, total word capacity (2..64); need not be a power of two.
- FWFT, 0, 0 = standard registered-read mode; 1 = first-word-fall-through mode.
- PROG_FULL_THRESH, 24, prog_full asserted when count >= this value.
- PROG_EMPTY_THRESH, 8, prog_empty asserted when count <= this value.
- COUNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of count output.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush; empties FIFO, same effect as reset except rd_data.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (FWFT: acknowledge/pop of presented word).
- rd_data  out  DATA_WIDTH  read data (standard: registered result; FWFT: head word).
- rd_valid  out  1  standard: rd_data updated this cycle; FWFT: rd_data holds a valid head word.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  standard: count == 0; FWFT: !rd_valid.
- prog_full  out  1  count >= PROG_FULL_THRESH.
- prog_empty  out  1  count <= PROG_EMPTY_THRESH.
- count  out  COUNT_WIDTH  words held, including the FWFT output register.
- overflow  out  1  one-cycle strobe: write rejected.
- underflow  out  1  one-cycle strobe: read rejected.

Behaviour:
- Reset (async, rst_n low):
  - Pointers = 0, count = 0, rd_data = 0, rd_valid = 0.
  - overflow = underflow = 0, empty = 1, full = 0, prog_empty = 1, prog_full = (PROG_FULL_THRESH == 0).
  - RAM contents are undefined.
- Read accept (rd_ok):
  - Standard mode: rd_en & (count != 0).
  - FWFT mode: rd_en & rd_valid.
- Write accept (wr_ok): wr_en & (!full | rd_ok); a write into a full FIFO with a simultaneous accepted read succeeds.
- Pointers:
  - wr_ptr/rd_ptr span 0..FIFO_DEPTH-1.
  - Increment on RAM write/read; wrap from FIFO_DEPTH-1 to 0 (explicit compare, not a binary rollover).
- count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged if both or neither.
  - Never exceeds FIFO_DEPTH and never underflows.
- Standard mode:
  - On rd_ok at edge N, rd_data <= RAM[rd_ptr] and rd_valid = 1 for the cycle after edge N. Otherwise rd_valid = 0 and rd_data holds its value.
  - Write-to-readable latency: data written at edge N may be read by rd_en sampled at edge N+1.
- FWFT mode:
  - Output register load: when (!rd_valid | rd_ok) and RAM holds >= 1 word, load RAM[rd_ptr], advance rd_ptr, set rd_valid = 1.
  - If rd_ok and RAM is empty: rd_valid <= 0, rd_data holds.
  - Write into an empty FIFO at edge N gives rd_valid = 1 after edge N+1 (2-edge fall-through latency).
  - count includes the output-register word, so capacity = FIFO_DEPTH in both modes.
  - Track RAM occupancy separately from count: it excludes the output-register word.
- overflow: registered, high the cycle after an edge where wr_en & !wr_ok. No state change; data dropped.
- underflow: registered, high the cycle after an edge where rd_en & !rd_ok. No pointer change; rd_data holds; rd_valid = 0 in standard mode.
- clr:
  - Sampled at the edge; priority over wr_en/rd_en at that edge (both ignored, no error strobes).
  - Next cycle: pointers = 0, count = 0, rd_valid = 0, overflow = underflow = 0; rd_data holds.
- Status outputs are combinational decodes of registered state only (glitch-free, no path from inputs).
- Asserting rst_n low mid-transfer clears everything immediately. The first post-reset write behaves as a write into an empty FIFO.

Test Plan:
- FWFT=0, DEPTH=32: write 0x01..0x20 on 32 consecutive cycles -> full=1, count=32, prog_full=1. A 33rd write -> overflow pulses 1 cycle, count stays 32. Then 32 reads -> rd_data 0x01..0x20 in order, each with rd_valid one cycle after rd_en, then empty=1.
- FWFT=1, DEPTH=5: single write 0xA5 at edge N -> rd_valid=1, rd_data=0xA5, count=1 after edge N+1. rd_en -> rd_valid=0, empty=1 next cycle.
- DEPTH=5 (non-power-of-two), both modes: 12 write/read cycles alternating 3-in/3-out -> pointers wrap 4->0 and data stays in order. Simultaneous wr_en+rd_en with full=1 -> count stays 5 and data stays in order.
- rd_en when empty -> underflow pulses 1 cycle; count stays 0; rd_data unchanged.
- Fill 10 words (PROG_EMPTY_THRESH=8, PROG_FULL_THRESH=24) -> prog_empty deasserts at count=9, prog_full stays 0. Assert clr with wr_en=1 -> count=0, empty=1, no write stored.
- Assert rst_n low mid-burst with count=7 -> all outputs return to reset values asynchronously. Resume writes -> first read returns the first post-reset word.
